// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the i-cache / d-cache read-path arbiter.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAddr,
    ArbData
  } arb_state_e;

  localparam logic ArbPortIc = 1'b0;
  localparam logic ArbPortDc = 1'b1;

  localparam int unsigned IdWidth = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// AXI channel bundle; each instance carries one channel, selected by modport.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = cache_mem_arbiter_pkg::IdWidth
);
  // Read address
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [LEN_WIDTH-1:0]  ARLEN;
  logic [ID_WIDTH-1:0]   ARID;
  // Read data
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [ID_WIDTH-1:0]   RID;
  // Write address
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [LEN_WIDTH-1:0]  AWLEN;
  logic [ID_WIDTH-1:0]   AWID;
  // Write data
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  // Write response
  logic                  BVALID;
  logic                  BREADY;
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;

  modport ar_master (output ARVALID, ARADDR, ARLEN, ARID, input ARREADY);
  modport ar_slave  (input ARVALID, ARADDR, ARLEN, ARID, output ARREADY);
  modport r_master  (input RVALID, RDATA, RID, output RREADY);
  modport r_slave   (output RVALID, RDATA, RID, input RREADY);
  modport aw_master (output AWVALID, AWADDR, AWLEN, AWID, input AWREADY);
  modport aw_slave  (input AWVALID, AWADDR, AWLEN, AWID, output AWREADY);
  modport w_master  (output WVALID, WDATA, WLAST, input WREADY);
  modport w_slave   (input WVALID, WDATA, WLAST, output WREADY);
  modport b_master  (input BVALID, BID, BRESP, output BREADY);
  modport b_slave   (output BVALID, BID, BRESP, input BREADY);

endinterface

// File: rtl/cache_mem_arbiter_rr_arbiter_2.sv
// Two-requester round-robin pick: on a tie, the port that did not win last time.
module cache_mem_arbiter_rr_arbiter_2
  import cache_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Combinational grant selection
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = ArbPortIc;
    if (&req_i) begin
      gnt_idx_o = ~last_grant_i;
    end else if (req_i[1]) begin
      gnt_idx_o = ArbPortDc;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the memory AXI read path between i-cache (port 0) and d-cache (port 1),
// one refill burst at a time; d-cache write channels pass straight through.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_mem_arbiter_if.ar_slave  ic_ar,
  cache_mem_arbiter_if.r_slave   ic_r,
  cache_mem_arbiter_if.ar_slave  dc_ar,
  cache_mem_arbiter_if.r_slave   dc_r,
  cache_mem_arbiter_if.aw_slave  dc_aw,
  cache_mem_arbiter_if.w_slave   dc_w,
  cache_mem_arbiter_if.b_slave   dc_b,
  cache_mem_arbiter_if.ar_master mem_ar,
  cache_mem_arbiter_if.r_master  mem_r,
  cache_mem_arbiter_if.aw_master mem_aw,
  cache_mem_arbiter_if.w_master  mem_w,
  cache_mem_arbiter_if.b_master  mem_b
);

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                 gnt_valid;
  logic                 gnt_idx;
  logic                 sel_arvalid;
  logic [LEN_WIDTH-1:0] sel_arlen;
  logic                 sel_rready;
  logic                 ar_hs;
  logic                 r_beat;

  cache_mem_arbiter_rr_arbiter_2 u_rr (
    .req_i        ({dc_ar.ARVALID, ic_ar.ARVALID}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  // Signals of the granted port; routing follows grant only, never RID
  assign sel_arvalid = grant_q ? dc_ar.ARVALID : ic_ar.ARVALID;
  assign sel_arlen   = grant_q ? dc_ar.ARLEN   : ic_ar.ARLEN;
  assign sel_rready  = grant_q ? dc_r.RREADY   : ic_r.RREADY;
  assign ar_hs       = (state_q == ArbAddr) && sel_arvalid && mem_ar.ARREADY;
  assign r_beat      = (state_q == ArbData) && mem_r.RVALID && sel_rready;

  // Read address mux: forwarded only while in the address phase
  always_comb begin
    mem_ar.ARVALID = 1'b0;
    mem_ar.ARADDR  = grant_q ? dc_ar.ARADDR : ic_ar.ARADDR;
    mem_ar.ARLEN   = sel_arlen;
    mem_ar.ARID    = grant_q ? dc_ar.ARID : ic_ar.ARID;
    ic_ar.ARREADY  = 1'b0;
    dc_ar.ARREADY  = 1'b0;
    if (state_q == ArbAddr) begin
      mem_ar.ARVALID = sel_arvalid;
      if (grant_q == ArbPortDc) begin
        dc_ar.ARREADY = mem_ar.ARREADY;
      end else begin
        ic_ar.ARREADY = mem_ar.ARREADY;
      end
    end
  end

  // Read data demux: beats arriving before the AR handshake are held off
  always_comb begin
    ic_r.RDATA   = mem_r.RDATA;
    ic_r.RID     = mem_r.RID;
    dc_r.RDATA   = mem_r.RDATA;
    dc_r.RID     = mem_r.RID;
    ic_r.RVALID  = 1'b0;
    dc_r.RVALID  = 1'b0;
    mem_r.RREADY = 1'b0;
    if (state_q == ArbData) begin
      mem_r.RREADY = sel_rready;
      if (grant_q == ArbPortIc) begin
        ic_r.RVALID = mem_r.RVALID;
      end else begin
        dc_r.RVALID = mem_r.RVALID;
      end
    end
  end

  // Write channels: stateless pass-through
  assign mem_aw.AWVALID = dc_aw.AWVALID;
  assign mem_aw.AWADDR  = dc_aw.AWADDR;
  assign mem_aw.AWLEN   = dc_aw.AWLEN;
  assign mem_aw.AWID    = dc_aw.AWID;
  assign dc_aw.AWREADY  = mem_aw.AWREADY;
  assign mem_w.WVALID   = dc_w.WVALID;
  assign mem_w.WDATA    = dc_w.WDATA;
  assign mem_w.WLAST    = dc_w.WLAST;
  assign dc_w.WREADY    = mem_w.WREADY;
  assign dc_b.BVALID    = mem_b.BVALID;
  assign dc_b.BID       = mem_b.BID;
  assign dc_b.BRESP     = mem_b.BRESP;
  assign mem_b.BREADY   = dc_b.BREADY;

  // Next-state: grant in idle, capture burst length on AR, count beats
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (gnt_valid) begin
          grant_d = gnt_idx;
          state_d = ArbAddr;
        end
      end
      ArbAddr: begin
        // A master dropping ARVALID here simply leaves us waiting
        if (ar_hs) begin
          len_d        = (sel_arlen == '0) ? LEN_WIDTH'(1) : sel_arlen;
          beat_cnt_d   = '0;
          last_grant_d = grant_q;
          state_d      = ArbData;
        end
      end
      ArbData: begin
        if (r_beat) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (beat_cnt_q == len_q - LEN_WIDTH'(1)) begin
            state_d = ArbIdle;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // State registers, synchronous active-low reset; port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ArbIdle;
      grant_q      <= ArbPortIc;
      last_grant_q <= ArbPortDc;
      len_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised bench for cache_mem_arbiter with a burst-level reference model.
module tb_cache_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW))
    ic_ar_if (), ic_r_if (), dc_ar_if (), dc_r_if (), dc_aw_if (), dc_w_if (), dc_b_if (),
    mem_ar_if (), mem_r_if (), mem_aw_if (), mem_w_if (), mem_b_if ();

  cache_mem_arbiter #(.LEN_WIDTH(LW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ic_ar  (ic_ar_if),
    .ic_r   (ic_r_if),
    .dc_ar  (dc_ar_if),
    .dc_r   (dc_r_if),
    .dc_aw  (dc_aw_if),
    .dc_w   (dc_w_if),
    .dc_b   (dc_b_if),
    .mem_ar (mem_ar_if),
    .mem_r  (mem_r_if),
    .mem_aw (mem_aw_if),
    .mem_w  (mem_w_if),
    .mem_b  (mem_b_if)
  );

  // Stimulus state
  logic          req_v [2];
  logic [AW-1:0] req_a [2];
  logic [LW-1:0] req_l [2];
  logic [IW-1:0] req_id[2];
  logic          rrdy  [2];
  logic          mem_arrdy, mem_rv;
  logic [DW-1:0] mem_rd;
  logic [IW-1:0] mem_rid;
  logic          aw_v, aw_rdy, w_v, w_last, w_rdy, b_v, b_rdy;
  logic [AW-1:0] aw_a;
  logic [LW-1:0] aw_l;
  logic [IW-1:0] aw_id, b_id;
  logic [DW-1:0] w_d;
  logic [1:0]    b_resp;

  assign ic_ar_if.ARVALID  = req_v[0];
  assign ic_ar_if.ARADDR   = req_a[0];
  assign ic_ar_if.ARLEN    = req_l[0];
  assign ic_ar_if.ARID     = req_id[0];
  assign dc_ar_if.ARVALID  = req_v[1];
  assign dc_ar_if.ARADDR   = req_a[1];
  assign dc_ar_if.ARLEN    = req_l[1];
  assign dc_ar_if.ARID     = req_id[1];
  assign ic_r_if.RREADY    = rrdy[0];
  assign dc_r_if.RREADY    = rrdy[1];
  assign mem_ar_if.ARREADY = mem_arrdy;
  assign mem_r_if.RVALID   = mem_rv;
  assign mem_r_if.RDATA    = mem_rd;
  assign mem_r_if.RID      = mem_rid;
  assign dc_aw_if.AWVALID  = aw_v;
  assign dc_aw_if.AWADDR   = aw_a;
  assign dc_aw_if.AWLEN    = aw_l;
  assign dc_aw_if.AWID     = aw_id;
  assign mem_aw_if.AWREADY = aw_rdy;
  assign dc_w_if.WVALID    = w_v;
  assign dc_w_if.WDATA     = w_d;
  assign dc_w_if.WLAST     = w_last;
  assign mem_w_if.WREADY   = w_rdy;
  assign mem_b_if.BVALID   = b_v;
  assign mem_b_if.BID      = b_id;
  assign mem_b_if.BRESP    = b_resp;
  assign dc_b_if.BREADY    = b_rdy;

  // Knobs
  int p_req[2], p_rrdy[2], budget[2];
  int p_arrdy, p_rv, rst_cycles;
  bit use_base;
  logic [DW-1:0] data_base;

  // Reference model: who owns the path and how many beats remain
  int  phase;  // 0 free, 1 waiting for AR accept, 2 streaming beats
  int  owner, last, beats_left;
  bit  model_ok, busy[2], clr_req[2];
  int  mq_len[$];
  logic [IW-1:0] mq_id[$];
  int  mq_sent;

  // Observations
  int            glog[$];
  logic [DW-1:0] dlog0[$], dlog1[$];
  int            ic_rdy_cnt, dc_rdy_cnt;

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic gen();
    rst_n = (rst_cycles == 0);
    if (rst_cycles > 0) rst_cycles--;
    for (int p = 0; p < 2; p++) begin
      if (clr_req[p]) begin
        req_v[p]   = 1'b0;
        clr_req[p] = 1'b0;
      end
      if (rst_n && !req_v[p] && !busy[p] && budget[p] != 0 && int'($urandom % 100) < p_req[p])
      begin
        req_v[p]  = 1'b1;
        req_a[p]  = $urandom;
        req_l[p]  = LW'($urandom_range(0, 8));
        req_id[p] = IW'(p);
        if (budget[p] > 0) budget[p]--;
      end
      rrdy[p] = int'($urandom % 100) < p_rrdy[p];
    end
    mem_arrdy = int'($urandom % 100) < p_arrdy;
    mem_rv    = (mq_len.size() > 0) && (int'($urandom % 100) < p_rv);
    mem_rd    = use_base ? data_base + DW'(mq_sent) : $urandom;
    mem_rid   = (mq_id.size() > 0) ? mq_id[0] : '0;
    aw_v = 1'($urandom); aw_a = $urandom; aw_l = LW'($urandom); aw_id = IW'($urandom);
    aw_rdy = 1'($urandom); w_v = 1'($urandom); w_d = $urandom; w_last = 1'($urandom);
    w_rdy = 1'($urandom); b_v = 1'($urandom); b_id = IW'($urandom); b_resp = 2'($urandom);
    b_rdy = 1'($urandom);
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    gen();
  endtask

  // Compare against the model, log observations, then advance the model
  task automatic cyc_end();
    logic e_arv, e_icar, e_dcar, e_icrv, e_dcrv, e_rrdy;
    int n;
    #2;
    if (model_ok) begin
      e_arv = 1'b0; e_icar = 1'b0; e_dcar = 1'b0;
      e_icrv = 1'b0; e_dcrv = 1'b0; e_rrdy = 1'b0;
      if (phase == 1) begin
        e_arv = req_v[owner];
        if (owner == 0) e_icar = mem_arrdy; else e_dcar = mem_arrdy;
      end else if (phase == 2) begin
        if (owner == 0) e_icrv = mem_rv; else e_dcrv = mem_rv;
        e_rrdy = rrdy[owner];
      end
      chk("mem_arvalid", mem_ar_if.ARVALID, e_arv);
      chk("ic_arready", ic_ar_if.ARREADY, e_icar);
      chk("dc_arready", dc_ar_if.ARREADY, e_dcar);
      chk("ic_rvalid", ic_r_if.RVALID, e_icrv);
      chk("dc_rvalid", dc_r_if.RVALID, e_dcrv);
      chk("mem_rready", mem_r_if.RREADY, e_rrdy);
      if (e_arv) begin
        chk("mem_ar_fields", {mem_ar_if.ARADDR, mem_ar_if.ARLEN, mem_ar_if.ARID},
            {req_a[owner], req_l[owner], req_id[owner]});
      end
      if (e_icrv) chk("ic_r_fields", {ic_r_if.RDATA, ic_r_if.RID}, {mem_rd, mem_rid});
      if (e_dcrv) chk("dc_r_fields", {dc_r_if.RDATA, dc_r_if.RID}, {mem_rd, mem_rid});
      chk("aw_pass", {mem_aw_if.AWVALID, mem_aw_if.AWADDR, mem_aw_if.AWLEN, mem_aw_if.AWID,
                      dc_aw_if.AWREADY}, {aw_v, aw_a, aw_l, aw_id, aw_rdy});
      chk("w_pass", {mem_w_if.WVALID, mem_w_if.WDATA, mem_w_if.WLAST, dc_w_if.WREADY},
          {w_v, w_d, w_last, w_rdy});
      chk("b_pass", {dc_b_if.BVALID, dc_b_if.BID, dc_b_if.BRESP, mem_b_if.BREADY},
          {b_v, b_id, b_resp, b_rdy});
    end
    if (rst_n) begin
      if (mem_ar_if.ARVALID === 1'b1 && mem_arrdy) glog.push_back(int'(mem_ar_if.ARID));
      if (ic_r_if.RVALID === 1'b1 && rrdy[0]) dlog0.push_back(ic_r_if.RDATA);
      if (dc_r_if.RVALID === 1'b1 && rrdy[1]) dlog1.push_back(dc_r_if.RDATA);
      if (ic_ar_if.ARREADY === 1'b1) ic_rdy_cnt++;
      if (dc_ar_if.ARREADY === 1'b1) dc_rdy_cnt++;
    end
    if (!rst_n) begin
      phase = 0; last = 1; beats_left = 0; mq_sent = 0;
      mq_len.delete(); mq_id.delete();
      busy[0] = 0; busy[1] = 0; clr_req[0] = 1; clr_req[1] = 1;
      model_ok = 1;
    end else if (phase == 0) begin
      if (req_v[0] || req_v[1]) begin
        if (req_v[0] && req_v[1]) owner = 1 - last;
        else owner = req_v[1] ? 1 : 0;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (req_v[owner] && mem_arrdy) begin
        n = (req_l[owner] == 0) ? 1 : int'(req_l[owner]);
        mq_len.push_back(n);
        mq_id.push_back(req_id[owner]);
        beats_left = n; last = owner; busy[owner] = 1; clr_req[owner] = 1;
        phase = 2;
      end
    end else if (mem_rv && rrdy[owner]) begin
      beats_left--;
      mq_sent++;
      if (mq_len.size() > 0 && mq_sent == mq_len[0]) begin
        void'(mq_len.pop_front());
        void'(mq_id.pop_front());
        mq_sent = 0;
      end
      if (beats_left == 0) begin
        busy[owner] = 0;
        phase = 0;
      end
    end
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset();
    rst_cycles = 2;
    repeat (2) step();
    glog.delete(); dlog0.delete(); dlog1.delete();
    ic_rdy_cnt = 0; dc_rdy_cnt = 0;
  endtask

  task automatic set_knobs(int preq0, int preq1, int parrdy, int prv, int prrdy);
    p_req[0] = preq0; p_req[1] = preq1; p_arrdy = parrdy; p_rv = prv;
    p_rrdy[0] = prrdy; p_rrdy[1] = prrdy; budget[0] = -1; budget[1] = -1;
  endtask

  initial begin
    int stall;
    bit stalled;
    logic [DW-1:0] exp_w;
    req_v[0] = 0; req_v[1] = 0; req_a[0] = '0; req_a[1] = '0; req_l[0] = '0; req_l[1] = '0;
    req_id[0] = '0; req_id[1] = '0; rrdy[0] = 0; rrdy[1] = 0;
    mem_arrdy = 0; mem_rv = 0; mem_rd = '0; mem_rid = '0;
    model_ok = 0; busy[0] = 0; busy[1] = 0; clr_req[0] = 0; clr_req[1] = 0;
    phase = 0; owner = 0; last = 1; mq_sent = 0; use_base = 1; data_base = 32'hA0;

    // Single i-cache refill at 0x100, 4 beats 0xA0..0xA3
    set_knobs(0, 0, 0, 0, 100);
    do_reset();
    chk("reset_outputs", {mem_ar_if.ARVALID, ic_ar_if.ARREADY, dc_ar_if.ARREADY,
                          ic_r_if.RVALID, dc_r_if.RVALID, mem_r_if.RREADY}, 6'b0);
    cyc_begin();
    req_v[0] = 1; req_a[0] = 32'h100; req_l[0] = 4'd4; req_id[0] = 4'd2;
    cyc_end();
    chk("t1_bubble", mem_ar_if.ARVALID, 1'b0);
    cyc_begin();
    mem_rv = 1;  // stray beat before the AR handshake
    cyc_end();
    chk("t1_araddr", {mem_ar_if.ARVALID, mem_ar_if.ARADDR}, {1'b1, 32'h100});
    chk("t1_early_beat", {ic_r_if.RVALID, mem_r_if.RREADY}, 2'b00);
    cyc_begin();
    mem_arrdy = 1;
    cyc_end();
    chk("t1_arready", ic_ar_if.ARREADY, 1'b1);
    p_rv = 100;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_w = 32'hA0 + DW'(i);
      chk("t1_beat", {ic_r_if.RVALID, ic_r_if.RDATA, dc_r_if.RVALID}, {1'b1, exp_w, 1'b0});
    end
    cyc_begin();
    mem_rv = 1;
    cyc_end();
    chk("t1_idle_after", {ic_r_if.RVALID, mem_r_if.RREADY}, 2'b00);

    // Simultaneous requests after reset: port 0 first, port 1 next
    set_knobs(100, 100, 100, 100, 100);
    budget[0] = 1; budget[1] = 1;
    do_reset();
    for (int c = 0; c < 80 && !(glog.size() == 2 && !busy[0] && !busy[1]); c++) step();
    chk("t2_grant_cnt", glog.size(), 2);
    if (glog.size() == 2) chk("t2_order", {glog[0][3:0], glog[1][3:0]}, 8'h01);
    chk("t2_dc_arready_cycles", dc_rdy_cnt, 1);

    // Round-robin fairness: port 0 always requesting, port 1 three times
    set_knobs(100, 100, 100, 100, 100);
    budget[1] = 3;
    do_reset();
    for (int c = 0; c < 400 && glog.size() < 6; c++) step();
    chk("t3_grant_cnt", glog.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("t3_grant", glog[i], i % 2);

    // Stall: d-cache drops RREADY for 2 cycles after beat 2
    set_knobs(0, 0, 100, 100, 100);
    data_base = 32'hB0;
    do_reset();
    cyc_begin();
    req_v[1] = 1; req_a[1] = 32'h240; req_l[1] = 4'd4; req_id[1] = 4'd1;
    cyc_end();
    stall = 2;
    for (int c = 0; c < 40 && dlog1.size() < 4; c++) begin
      cyc_begin();
      stalled = (dlog1.size() == 2 && stall > 0);
      if (stalled) begin
        rrdy[1] = 0;
        stall--;
      end
      cyc_end();
      if (stalled) chk("t4_stall_rready", mem_r_if.RREADY, 1'b0);
    end
    chk("t4_words", dlog1.size(), 4);
    for (int i = 0; i < 4 && i < dlog1.size(); i++) begin
      exp_w = 32'hB0 + DW'(i);
      chk("t4_data", dlog1[i], exp_w);
    end

    // Reset in the middle of a burst, then a fresh port 1 request
    set_knobs(0, 0, 100, 100, 100);
    data_base = 32'hC0;
    do_reset();
    cyc_begin();
    req_v[0] = 1; req_a[0] = 32'h180; req_l[0] = 4'd4; req_id[0] = 4'd0;
    cyc_end();
    for (int c = 0; c < 20 && dlog0.size() < 2; c++) step();
    chk("t5_two_beats", dlog0.size(), 2);
    rst_cycles = 1;
    step();
    cyc_begin();
    req_v[1] = 1; req_a[1] = 32'h2C0; req_l[1] = 4'd2; req_id[1] = 4'd1;
    cyc_end();
    chk("t5_idle", {mem_ar_if.ARVALID, ic_ar_if.ARREADY, dc_ar_if.ARREADY,
                    ic_r_if.RVALID, dc_r_if.RVALID, mem_r_if.RREADY}, 6'b0);
    step();
    chk("t5_regrant", {mem_ar_if.ARVALID, mem_ar_if.ARID, mem_ar_if.ARADDR},
        {1'b1, 4'd1, 32'h2C0});
    for (int c = 0; c < 20 && (busy[1] || req_v[1]); c++) step();

    // Write traffic overlapping an i-cache read
    set_knobs(100, 0, 100, 100, 100);
    data_base = 32'hD0;
    do_reset();
    for (int c = 0; c < 6; c++) step();
    cyc_begin();
    aw_v = 1; aw_a = 32'h400; b_v = 1; b_rdy = 0; w_d = 32'hDEAD_0001; w_v = 1;
    cyc_end();
    chk("t6_aw", {mem_aw_if.AWVALID, mem_aw_if.AWADDR}, {1'b1, 32'h400});
    chk("t6_w", mem_w_if.WDATA, 32'hDEAD_0001);
    chk("t6_b", {dc_b_if.BVALID, mem_b_if.BREADY}, 2'b10);
    for (int c = 0; c < 20; c++) step();
    chk("t6_read_progress", glog.size() >= 2, 1'b1);

    // Fully random traffic with occasional resets
    use_base = 0;
    set_knobs(30, 30, 50, 70, 70);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) rst_cycles = 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
